// File: rtl/inval_line_queue.sv
// Line-granular invalidation queue between the memory-path filter and CVA6; coalesces requests to lines already queued.
// Latency: an accepted push appears on inval_valid_o the next cycle; head data and valid are driven from registers only.
// Backpressure: inval_ready_o drops only when full with no hit; it never depends on inval_ready_i.
module inval_line_queue #(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned L1LineWidth = 16,
    parameter int unsigned Depth       = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic [AddrWidth-1:0]       inval_addr_i,
    input  logic                       inval_valid_i,
    output logic                       inval_ready_o,
    output logic [AddrWidth-1:0]       inval_addr_o,
    output logic                       inval_valid_o,
    input  logic                       inval_ready_i,
    output logic [$clog2(Depth):0]     usage_o,
    output logic                       coalesce_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [AddrWidth-1:0] mem_q [Depth];
    logic [Depth-1:0]     occ_q;
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q;
    logic                 coalesce_q;

    logic [AddrWidth-1:0] line_i;
    logic                 full, empty, pop, push, acc;
    logic                 hit, match_nohead;

    assign line_i = inval_addr_i & ~AddrWidth'(L1LineWidth - 1);
    assign full   = (count_q == CntW'(Depth));
    assign empty  = (count_q == '0);
    assign pop    = ~empty & inval_ready_i;

    // hit decides push vs. coalesce and may exclude the popping head; match_nohead
    // always excludes the head so that inval_ready_o stays free of inval_ready_i.
    always_comb begin
        hit          = 1'b0;
        match_nohead = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            if (occ_q[i] && (mem_q[i] == line_i)) begin
                if (PtrW'(i) != rd_ptr_q) match_nohead = 1'b1;
                if (!(pop && (PtrW'(i) == rd_ptr_q))) hit = 1'b1;
            end
        end
    end

    assign inval_ready_o = en_i ? (~full | match_nohead) : 1'b1;
    assign acc           = inval_valid_i & inval_ready_o & en_i;
    assign push          = acc & ~hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q      <= '{default: '0};
            occ_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            coalesce_q <= 1'b0;
        end else begin
            coalesce_q <= acc & hit;
            if (pop) begin
                occ_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + PtrW'(1);
            end
            if (push) begin
                mem_q[wr_ptr_q] <= line_i;
                occ_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign inval_valid_o = ~empty;
    assign inval_addr_o  = mem_q[rd_ptr_q];
    assign usage_o       = count_q;
    assign coalesce_o    = coalesce_q;

    logic dup_line;
    always_comb begin
        dup_line = 1'b0;
        for (int i = 0; i < Depth; i++)
            for (int j = i + 1; j < Depth; j++)
                if (occ_q[i] && occ_q[j] && (mem_q[i] == mem_q[j])) dup_line = 1'b1;
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(inval_valid_o && inval_ready_i && empty));
    a_usage_bound:  assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= CntW'(Depth));
    a_unique_lines: assert property (@(posedge clk_i) disable iff (!rst_ni) !dup_line);
    a_in_stable:    assert property (@(posedge clk_i) disable iff (!rst_ni)
                        (inval_valid_i && !inval_ready_o) |=> (inval_valid_i && $stable(inval_addr_i)));

endmodule

// File: tb/tb_inval_line_queue.sv
// Directed bench for inval_line_queue: expected deliveries are queued at stimulus time and checked by a monitor.
module tb_inval_line_queue;

    localparam int K_PUSH = 0;
    localparam int K_COAL = 1;
    localparam int K_DROP = 2;
    localparam int K_LOST = 3;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en_i = 1'b1;
    logic [63:0] inval_addr_i = '0;
    logic        inval_valid_i = 1'b0;
    logic        inval_ready_o;
    logic [63:0] inval_addr_o;
    logic        inval_valid_o;
    logic        inval_ready_i = 1'b0;
    logic [2:0]  usage_o;
    logic        coalesce_o;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          rnd_on = 1'b0;
    logic [63:0] exp_q[$];

    inval_line_queue #(.AddrWidth(64), .L1LineWidth(16), .Depth(4)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .inval_addr_i  (inval_addr_i),
        .inval_valid_i (inval_valid_i),
        .inval_ready_o (inval_ready_o),
        .inval_addr_o  (inval_addr_o),
        .inval_valid_o (inval_valid_o),
        .inval_ready_i (inval_ready_i),
        .usage_o       (usage_o),
        .coalesce_o    (coalesce_o)
    );

    always #5 clk_i = ~clk_i;

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    initial forever begin
        @(posedge clk_i);
        #1;
        if (rnd_on) inval_ready_i = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every head transfer must match the next expected line.
    always @(negedge clk_i) begin
        if (rst_ni && inval_valid_o && inval_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", inval_addr_o, 64'hdead);
            end else begin
                check("pop_addr", inval_addr_o, exp_q.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic push_req(input logic [63:0] a, input int kind, input logic [63:0] exp_line,
                            output int hs_cyc, output int waits);
        inval_addr_i  = a;
        inval_valid_i = 1'b1;
        waits  = 0;
        hs_cyc = -1;
        forever begin
            @(negedge clk_i);
            if (inval_ready_o) break;
            waits++;
            if (waits > 50) begin
                check("push_timeout", 64'(waits), 64'd50);
                inval_valid_i = 1'b0;
                return;
            end
            @(posedge clk_i);
            #1;
        end
        @(posedge clk_i);
        #1;
        hs_cyc = cyc;
        inval_valid_i = 1'b0;
        if (kind == K_PUSH) exp_q.push_back(exp_line);
        check("coalesce_pulse", 64'(coalesce_o), (kind == K_COAL) ? 64'd1 : 64'd0);
    endtask

    task automatic push(input logic [63:0] a, input int kind, input logic [63:0] exp_line);
        int h, w;
        push_req(a, kind, exp_line, h, w);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (usage_o != 0 && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        #1;
        check(name, 64'(usage_o), 64'd0);
        check("drain_all_delivered", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int h, w, t_ready;

        #12;
        check("rst_valid", 64'(inval_valid_o), 64'd0);
        check("rst_addr",  inval_addr_o, 64'd0);
        check("rst_usage", 64'(usage_o), 64'd0);
        check("rst_coal",  64'(coalesce_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Single request with immediate acceptance
        inval_ready_i = 1'b1;
        push(64'h8000_1234, K_PUSH, 64'h8000_1230);
        check("single_valid_lat1", 64'(inval_valid_o), 64'd1);
        check("single_usage1", 64'(usage_o), 64'd1);
        @(posedge clk_i);
        #1;
        check("single_usage0", 64'(usage_o), 64'd0);

        // Coalesce within a line
        inval_ready_i = 1'b0;
        push(64'h100, K_PUSH, 64'h100);
        push(64'h104, K_COAL, 64'h0);
        push(64'h10F, K_COAL, 64'h0);
        push(64'h110, K_PUSH, 64'h110);
        check("coal_usage2", 64'(usage_o), 64'd2);
        inval_ready_i = 1'b1;
        drain("coal_drain");

        // Full back-pressure, hit while full, release after first pop
        @(posedge clk_i);
        #1;
        inval_ready_i = 1'b0;
        push(64'h00, K_PUSH, 64'h00);
        push(64'h10, K_PUSH, 64'h10);
        push(64'h20, K_PUSH, 64'h20);
        push(64'h30, K_PUSH, 64'h30);
        check("full_usage4", 64'(usage_o), 64'd4);
        push(64'h24, K_COAL, 64'h0);
        check("full_hit_usage4", 64'(usage_o), 64'd4);
        t_ready = 0;
        fork
            push_req(64'h40, K_PUSH, 64'h40, h, w);
            begin
                repeat (3) begin
                    @(negedge clk_i);
                    check("full_stall_ready", 64'(inval_ready_o), 64'd0);
                end
                @(posedge clk_i);
                #1;
                t_ready = cyc;
                inval_ready_i = 1'b1;
            end
        join
        check("full_accept_cycle", 64'(h), 64'(t_ready + 2));
        drain("full_drain");

        // Pop the head while pushing the same line
        @(posedge clk_i);
        #1;
        inval_ready_i = 1'b0;
        push(64'h200, K_PUSH, 64'h200);
        inval_ready_i = 1'b1;
        push(64'h208, K_PUSH, 64'h200);
        check("race_usage1", 64'(usage_o), 64'd1);
        check("race_valid", 64'(inval_valid_o), 64'd1);
        drain("race_drain");

        // Disabled coherence: discard but keep draining
        @(posedge clk_i);
        #1;
        inval_ready_i = 1'b0;
        push(64'h300, K_PUSH, 64'h300);
        push(64'h310, K_PUSH, 64'h310);
        en_i = 1'b0;
        push_req(64'h400, K_DROP, 64'h0, h, w);
        check("dis_ready_wait", 64'(w), 64'd0);
        check("dis_usage2", 64'(usage_o), 64'd2);
        inval_ready_i = 1'b1;
        drain("dis_drain");
        en_i = 1'b1;

        // Wrap-around with random acceptance
        @(posedge clk_i);
        #1;
        rnd_on = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push(64'h1000 + 64'(i) * 64'h10 + 64'(i % 16), K_PUSH, 64'h1000 + 64'(i) * 64'h10);
        end
        rnd_on = 1'b0;
        inval_ready_i = 1'b1;
        drain("wrap_drain");

        // Asynchronous reset with entries queued
        @(posedge clk_i);
        #1;
        inval_ready_i = 1'b0;
        push(64'h600, K_LOST, 64'h0);
        push(64'h610, K_LOST, 64'h0);
        push(64'h620, K_LOST, 64'h0);
        check("pre_rst_usage3", 64'(usage_o), 64'd3);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_valid", 64'(inval_valid_o), 64'd0);
        check("arst_usage", 64'(usage_o), 64'd0);
        check("arst_addr", inval_addr_o, 64'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        inval_ready_i = 1'b1;
        push(64'h5558, K_PUSH, 64'h5550);
        check("post_rst_valid", 64'(inval_valid_o), 64'd1);
        drain("post_rst_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
